// File: rtl/mat_pkg.sv
// rtl/mat_pkg.sv - shared FSM state type and the signed Q-format round/saturate rule
// Contents: mvm_state_t (IDLE, MAC, DONE), q_rs_t result struct, q_round_sat().
// q_round_sat is the single rounding rule for the matrix stages: round half-up, then clip.
package mat_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } mvm_state_t;

  // Widest accumulator the rounding rule accepts; callers sign-extend into it.
  localparam int Q_MAX_W = 64;

  typedef struct packed {
    logic                      sat;
    logic signed [Q_MAX_W-1:0] val;
  } q_rs_t;

  // Add half an output LSB, arithmetic shift by qbits (floor), then clip to a
  // signed width-bit range. sat reports that clipping happened.
  function automatic q_rs_t q_round_sat(input logic signed [Q_MAX_W-1:0] acc,
                                        input int                        width,
                                        input int                        qbits);
    logic signed [Q_MAX_W-1:0] half;
    logic signed [Q_MAX_W-1:0] rounded;
    logic signed [Q_MAX_W-1:0] max_v;
    logic signed [Q_MAX_W-1:0] min_v;
    q_rs_t                     r;
    half    = 64'sd1 <<< (qbits - 1);
    rounded = (acc + half) >>> qbits;
    max_v   = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v   = -(64'sd1 <<< (width - 1));
    r.sat   = 1'b0;
    r.val   = rounded;
    if (rounded > max_v) begin
      r.sat = 1'b1;
      r.val = max_v;
    end else if (rounded < min_v) begin
      r.sat = 1'b1;
      r.val = min_v;
    end
    return r;
  endfunction

endpackage

// File: rtl/q_round_sat_unit.sv
// rtl/q_round_sat_unit.sv - combinational wrapper around mat_pkg::q_round_sat
// Ports: i_acc  signed ACC_W-bit accumulator value (2*QBITS fractional bits)
//        o_res  signed WIDTH-bit rounded, saturated result (QBITS fractional bits)
//        o_sat  high when the result was clipped
module q_round_sat_unit
  import mat_pkg::*;
#(
  parameter int ACC_W = 34,
  parameter int WIDTH = 16,
  parameter int QBITS = 8
) (
  input  logic signed [ACC_W-1:0] i_acc,
  output logic signed [WIDTH-1:0] o_res,
  output logic                    o_sat
);

  logic signed [Q_MAX_W-1:0]     acc_ext;
  q_rs_t                         rs;
  logic [Q_MAX_W-WIDTH-1:0]      unused_hi;

  always_comb begin
    acc_ext   = {{(Q_MAX_W-ACC_W){i_acc[ACC_W-1]}}, i_acc};
    rs        = q_round_sat(acc_ext, WIDTH, QBITS);
    o_res     = rs.val[WIDTH-1:0];
    o_sat     = rs.sat;
    // After clipping the upper bits are pure sign extension.
    unused_hi = rs.val[Q_MAX_W-1:WIDTH];
  end

endmodule

// File: rtl/mat_vec_mul.sv
// rtl/mat_vec_mul.sv - single-MAC fixed-point matrix-vector multiplier (o_vec = mat * vec)
// Ports: i_clk, i_rst (synchronous, active high), i_start (sampled in IDLE only),
//        i_mat  ORDER*ORDER row-major signed Q elements, i_vec ORDER signed Q elements,
//        o_vec  ORDER-element result, held between operations,
//        o_busy operation in progress, o_done one-cycle completion pulse,
//        o_sat  some element of the last result was clipped.
module mat_vec_mul
  import mat_pkg::*;
#(
  parameter int ORDER = 3,
  parameter int WIDTH = 16,
  parameter int QBITS = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic signed [WIDTH-1:0] i_mat [ORDER*ORDER],
  input  logic signed [WIDTH-1:0] i_vec [ORDER],
  output logic signed [WIDTH-1:0] o_vec [ORDER],
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_sat
);

  localparam int N      = ORDER * ORDER;
  localparam int ACC_W  = 2 * WIDTH + $clog2(ORDER);
  localparam int IDX_W  = (ORDER > 1) ? $clog2(ORDER) : 1;
  localparam int MIDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ORDER - 1);

  mvm_state_t              state_q, state_d;
  logic [IDX_W-1:0]        row_q, row_d;
  logic [IDX_W-1:0]        col_q, col_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    sat_q, sat_d;
  logic signed [WIDTH-1:0] mat_q [N];
  logic signed [WIDTH-1:0] mat_d [N];
  logic signed [WIDTH-1:0] vec_q [ORDER];
  logic signed [WIDTH-1:0] vec_d [ORDER];
  logic signed [WIDTH-1:0] res_q [ORDER];
  logic signed [WIDTH-1:0] res_d [ORDER];
  logic signed [WIDTH-1:0] vout_q [ORDER];
  logic signed [WIDTH-1:0] vout_d [ORDER];
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    osat_q, osat_d;

  logic [MIDX_W-1:0]       mat_idx;
  logic signed [WIDTH-1:0] mat_elem;
  logic signed [WIDTH-1:0] vec_elem;
  logic signed [ACC_W-1:0] mat_ext;
  logic signed [ACC_W-1:0] vec_ext;
  logic signed [ACC_W-1:0] prod;
  logic signed [ACC_W-1:0] sum;
  logic signed [WIDTH-1:0] rs_val;
  logic                    rs_sat;

  // Rounds the running row sum including the current product, used on the last column.
  q_round_sat_unit #(
    .ACC_W (ACC_W),
    .WIDTH (WIDTH),
    .QBITS (QBITS)
  ) u_round_sat (
    .i_acc (sum),
    .o_res (rs_val),
    .o_sat (rs_sat)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    mat_d   = mat_q;
    vec_d   = vec_q;
    res_d   = res_q;
    vout_d  = vout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    osat_d  = osat_q;

    mat_idx  = MIDX_W'(row_q) * MIDX_W'(ORDER) + MIDX_W'(col_q);
    mat_elem = mat_q[mat_idx];
    vec_elem = vec_q[col_q];
    // Operands are sign-extended to the accumulator width so the low ACC_W bits
    // of the product equal the exact 2*WIDTH-bit signed product.
    mat_ext  = {{(ACC_W-WIDTH){mat_elem[WIDTH-1]}}, mat_elem};
    vec_ext  = {{(ACC_W-WIDTH){vec_elem[WIDTH-1]}}, vec_elem};
    prod     = mat_ext * vec_ext;
    sum      = acc_q + prod;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          mat_d   = i_mat;
          vec_d   = i_vec;
          acc_d   = '0;
          row_d   = '0;
          col_d   = '0;
          sat_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        if (col_q == LAST) begin
          res_d[row_q] = rs_val;
          sat_d        = sat_q | rs_sat;
          acc_d        = '0;
          col_d        = '0;
          row_d        = row_q + IDX_W'(1);
          if (row_q == LAST) begin
            // res_d already holds the element produced this cycle.
            vout_d  = res_d;
            osat_d  = sat_q | rs_sat;
            done_d  = 1'b1;
            row_d   = '0;
            state_d = DONE;
          end
        end else begin
          acc_d = sum;
          col_d = col_q + IDX_W'(1);
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      osat_q  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        mat_q[i] <= '0;
      end
      for (int i = 0; i < ORDER; i++) begin
        vec_q[i]  <= '0;
        res_q[i]  <= '0;
        vout_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      osat_q  <= osat_d;
      for (int i = 0; i < N; i++) begin
        mat_q[i] <= mat_d[i];
      end
      for (int i = 0; i < ORDER; i++) begin
        vec_q[i]  <= vec_d[i];
        res_q[i]  <= res_d[i];
        vout_q[i] <= vout_d[i];
      end
    end
  end

  always_comb begin
    o_vec  = vout_q;
    o_busy = busy_q;
    o_done = done_q;
    o_sat  = osat_q;
  end

endmodule

// File: tb/tb_mat_vec_mul.sv
// tb/tb_mat_vec_mul.sv - self-checking bench for mat_vec_mul with a behavioural reference model
module tb_mat_vec_mul;

  localparam int ORDER = 3;
  localparam int WIDTH = 16;
  localparam int QBITS = 8;
  localparam int N     = ORDER * ORDER;
  localparam longint MAXV = (longint'(1) <<< (WIDTH - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (WIDTH - 1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic signed [WIDTH-1:0] mat [N];
  logic signed [WIDTH-1:0] vec [ORDER];
  logic signed [WIDTH-1:0] o_vec [ORDER];
  logic busy, done, sat;

  int checks = 0;
  int errors = 0;

  mat_vec_mul #(
    .ORDER (ORDER),
    .WIDTH (WIDTH),
    .QBITS (QBITS)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_mat   (mat),
    .i_vec   (vec),
    .o_vec   (o_vec),
    .o_busy  (busy),
    .o_done  (done),
    .o_sat   (sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // k counts cycles since a start was accepted; 0 means idle.
  // Busy for k = 1..N+1, done on k = N+1, then back to idle.
  int m_k = 0;
  int snap_m [N];
  int snap_v [ORDER];
  logic signed [WIDTH-1:0] exp_vec [ORDER];
  logic exp_sat = 1'b0;

  initial begin
    for (int i = 0; i < ORDER; i++) exp_vec[i] = '0;
  end

  task automatic model_result();
    longint s;
    logic   any_sat;
    any_sat = 1'b0;
    for (int r = 0; r < ORDER; r++) begin
      s = 0;
      for (int c = 0; c < ORDER; c++) begin
        s = s + longint'(snap_m[r*ORDER+c]) * longint'(snap_v[c]);
      end
      s = (s + (longint'(1) <<< (QBITS - 1))) >>> QBITS;
      if (s > MAXV) begin
        s = MAXV;
        any_sat = 1'b1;
      end else if (s < MINV) begin
        s = MINV;
        any_sat = 1'b1;
      end
      exp_vec[r] = WIDTH'(s);
    end
    exp_sat = any_sat;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_k = 0;
      for (int i = 0; i < ORDER; i++) exp_vec[i] = '0;
      exp_sat = 1'b0;
    end else if (m_k == 0) begin
      if (start) begin
        m_k = 1;
        for (int i = 0; i < N; i++) snap_m[i] = int'(mat[i]);
        for (int i = 0; i < ORDER; i++) snap_v[i] = int'(vec[i]);
      end
    end else if (m_k == N + 1) begin
      m_k = 0;
    end else begin
      m_k++;
      if (m_k == N + 1) model_result();
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("o_busy", 16'(busy), 16'(m_k != 0));
    chk("o_done", 16'(done), 16'(m_k == N + 1));
    chk("o_sat", 16'(sat), 16'(exp_sat));
    for (int i = 0; i < ORDER; i++) begin
      chk($sformatf("o_vec[%0d]", i), o_vec[i], exp_vec[i]);
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input bit scramble, output int lat);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 30) begin
      tick();
      lat++;
      if (scramble && lat < 5) begin
        for (int i = 0; i < N; i++) mat[i] = WIDTH'($urandom_range(0, 65535));
        for (int i = 0; i < ORDER; i++) vec[i] = WIDTH'($urandom_range(0, 65535));
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL done_timeout: got no o_done expected pulse within 30 cycles at %0t", $time);
    end
    tick();
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while (busy && b < 40) begin
      tick();
      b++;
    end
    if (busy) begin
      errors++;
      $display("FAIL idle_timeout: got o_busy=1 expected 0 within 40 cycles at %0t", $time);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c);
    chk({nm, "[0]"}, o_vec[0], a);
    chk({nm, "[1]"}, o_vec[1], b);
    chk({nm, "[2]"}, o_vec[2], c);
  endtask

  task automatic set_identity();
    for (int i = 0; i < N; i++) mat[i] = (i % (ORDER + 1) == 0) ? 16'sh0100 : 16'sh0000;
    vec[0] = 16'sh0180;
    vec[1] = 16'shFF00;
    vec[2] = 16'sh0040;
  endtask

  task automatic set_all(input logic [15:0] m, input logic [15:0] v);
    for (int i = 0; i < N; i++) mat[i] = m;
    for (int i = 0; i < ORDER; i++) vec[i] = v;
  endtask

  initial begin
    int lat;
    int pulses;
    int last;

    for (int i = 0; i < N; i++) mat[i] = '0;
    for (int i = 0; i < ORDER; i++) vec[i] = '0;

    rst = 1'b1;
    repeat (3) tick();
    chk("reset_busy", 16'(busy), 16'd0);
    chk("reset_done", 16'(done), 16'd0);
    chk("reset_sat", 16'(sat), 16'd0);
    chk_vec("reset_vec", 16'h0000, 16'h0000, 16'h0000);
    rst = 1'b0;
    tick();

    // Identity
    set_identity();
    run_op(1'b0, lat);
    chk("ident_latency", 16'(lat), 16'd9);
    chk_vec("ident_vec", 16'h0180, 16'hFF00, 16'h0040);
    chk("ident_sat", 16'(sat), 16'd0);

    // Scaling: 2.0 * (1+1+1) = 6.0
    set_all(16'h0200, 16'h0100);
    run_op(1'b0, lat);
    chk_vec("scale_vec", 16'h0600, 16'h0600, 16'h0600);
    chk("scale_sat", 16'(sat), 16'd0);

    // Rounding: 3 * 0x80 = 0x180 -> 1.5 LSB rounds up to 2; negative gives -1
    set_all(16'h0001, 16'h0080);
    run_op(1'b0, lat);
    chk_vec("round_pos_vec", 16'h0002, 16'h0002, 16'h0002);
    set_all(16'hFFFF, 16'h0080);
    run_op(1'b0, lat);
    chk_vec("round_neg_vec", 16'hFFFF, 16'hFFFF, 16'hFFFF);

    // Saturation, positive then negative
    set_all(16'h0000, 16'h0000);
    mat[0] = 16'sh7F00;
    mat[1] = 16'sh7F00;
    vec[0] = 16'sh0200;
    vec[1] = 16'sh0200;
    run_op(1'b0, lat);
    chk_vec("sat_pos_vec", 16'h7FFF, 16'h0000, 16'h0000);
    chk("sat_pos_flag", 16'(sat), 16'd1);
    mat[0] = 16'sh8100;
    mat[1] = 16'sh8100;
    run_op(1'b0, lat);
    chk_vec("sat_neg_vec", 16'h8000, 16'h0000, 16'h0000);
    chk("sat_neg_flag", 16'(sat), 16'd1);

    // Reset sampled at E4, mid-MAC
    set_identity();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("midrst_busy", 16'(busy), 16'd0);
    chk("midrst_done", 16'(done), 16'd0);
    chk("midrst_sat", 16'(sat), 16'd0);
    chk_vec("midrst_vec", 16'h0000, 16'h0000, 16'h0000);
    rst = 1'b0;
    tick();
    run_op(1'b0, lat);
    chk("midrst_latency", 16'(lat), 16'd9);
    chk_vec("midrst_fresh_vec", 16'h0180, 16'hFF00, 16'h0040);

    // Inputs changing after acceptance must not affect the result
    set_identity();
    run_op(1'b1, lat);
    chk_vec("scramble_vec", 16'h0180, 16'hFF00, 16'h0040);
    chk("scramble_sat", 16'(sat), 16'd0);

    // i_start held high: one operation every N+2 cycles
    set_all(16'h0200, 16'h0100);
    start = 1'b1;
    pulses = 0;
    last = -1;
    for (int n = 1; n <= 46; n++) begin
      tick();
      if (done) begin
        if (last >= 0) chk("done_spacing", 16'(n - last), 16'd11);
        last = n;
        pulses++;
      end
    end
    start = 1'b0;
    chk("held_pulses", 16'(pulses), 16'd4);
    wait_idle();
    chk_vec("held_vec", 16'h0600, 16'h0600, 16'h0600);

    // Randomized operations, alternating small-magnitude and full-range data
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < N; i++) begin
        if (t % 2 == 0) mat[i] = WIDTH'(int'($urandom_range(0, 1023)) - 512);
        else            mat[i] = WIDTH'($urandom_range(0, 65535));
      end
      for (int i = 0; i < ORDER; i++) begin
        if (t % 2 == 0) vec[i] = WIDTH'(int'($urandom_range(0, 2047)) - 1024);
        else            vec[i] = WIDTH'($urandom_range(0, 65535));
      end
      run_op(1'b0, lat);
      chk("rand_latency", 16'(lat), 16'd9);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
